// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the backing-memory port arbiter.
package mem_arb_pkg;

   // Arbiter FSM: accept a request, present it to memory, wait for its response
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } arb_state_t;

   // Which requester owns the transaction in flight
   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } owner_t;

   // Byte-enable pattern of a read; fetches always use it
   localparam logic [3:0] WE_READ = 4'b0000;

endpackage

// File: rtl/arb_starve_guard.sv
// Winner selection between fetch and data requesters. Data normally wins;
// once data has been granted STARVE_MAX times in a row while a fetch was
// waiting, the fetch is given the next grant.
module arb_starve_guard
   import mem_arb_pkg::*;
#(
   parameter int STARVE_MAX = 4
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   fetch_valid,
   input  logic   data_valid,
   input  logic   grant,
   input  owner_t grant_owner,
   output owner_t winner
);

   localparam int CNT_W = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

   logic [CNT_W-1:0] starve_cnt;

   // Data wins unless the waiting fetch has been passed over too often
   always_comb begin
      winner = OWN_I;
      if (data_valid && !(fetch_valid && (starve_cnt == CNT_MAX)))
         winner = OWN_D;
   end

   // Count consecutive data grants taken while a fetch was pending
   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt <= '0;
      end else if (grant) begin
         if ((grant_owner == OWN_D) && fetch_valid) begin
            if (starve_cnt != CNT_MAX)
               starve_cnt <= starve_cnt + CNT_W'(1);
         end else begin
            starve_cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one request/response memory port between instruction fetch and
// data access, one transaction at a time, and produces the pipeline stall.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req_valid,
   input  logic [ADDR_W-1:0] i_req_addr,
   output logic              i_req_ready,
   output logic              i_resp_valid,
   output logic [DATA_W-1:0] i_resp_data,
   input  logic              d_req_valid,
   input  logic [ADDR_W-1:0] d_req_addr,
   input  logic [3:0]        d_req_we,
   input  logic [DATA_W-1:0] d_req_wdata,
   output logic              d_req_ready,
   output logic              d_resp_valid,
   output logic [DATA_W-1:0] d_resp_data,
   output logic              mem_req_valid,
   output logic [ADDR_W-1:0] mem_req_addr,
   output logic [3:0]        mem_req_we,
   output logic [DATA_W-1:0] mem_req_wdata,
   input  logic              mem_req_ready,
   input  logic              mem_resp_valid,
   input  logic [DATA_W-1:0] mem_resp_data,
   output logic              stall
);

   arb_state_t        state, state_nxt;
   owner_t            owner, winner;
   logic              grant;
   logic [ADDR_W-1:0] addr_q;
   logic [3:0]        we_q;
   logic [DATA_W-1:0] wdata_q;

   arb_starve_guard #(
      .STARVE_MAX (STARVE_MAX)
   ) u_guard (
      .clk         (clk),
      .rst         (rst),
      .fetch_valid (i_req_valid),
      .data_valid  (d_req_valid),
      .grant       (grant),
      .grant_owner (winner),
      .winner      (winner)
   );

   // Next state, grant strobe, readies and response routing
   always_comb begin
      state_nxt     = state;
      grant         = 1'b0;
      i_req_ready   = 1'b0;
      d_req_ready   = 1'b0;
      mem_req_valid = 1'b0;
      i_resp_valid  = 1'b0;
      d_resp_valid  = 1'b0;
      case (state)
         IDLE: begin
            if (i_req_valid || d_req_valid) begin
               grant     = 1'b1;
               state_nxt = ISSUE;
               if (winner == OWN_D) d_req_ready = 1'b1;
               else                 i_req_ready = 1'b1;
            end
         end
         ISSUE: begin
            mem_req_valid = 1'b1;
            if (mem_req_ready) state_nxt = WAIT;
         end
         WAIT: begin
            if (mem_resp_valid) begin
               state_nxt = IDLE;
               if (owner == OWN_D) d_resp_valid = 1'b1;
               else                i_resp_valid = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register and capture of the granted request's fields
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         owner   <= OWN_I;
         addr_q  <= '0;
         we_q    <= WE_READ;
         wdata_q <= '0;
      end else begin
         state <= state_nxt;
         if (grant) begin
            owner <= winner;
            if (winner == OWN_D) begin
               addr_q  <= d_req_addr;
               we_q    <= d_req_we;
               wdata_q <= d_req_wdata;
            end else begin
               addr_q  <= i_req_addr;
               we_q    <= WE_READ;
               wdata_q <= '0;
            end
         end
      end
   end

   assign mem_req_addr  = addr_q;
   assign mem_req_we    = we_q;
   assign mem_req_wdata = wdata_q;

   // Response data only shows through to the requester being answered
   assign i_resp_data = i_resp_valid ? mem_resp_data : '0;
   assign d_resp_data = d_resp_valid ? mem_resp_data : '0;

   assign stall = (state != IDLE) | i_req_valid | d_req_valid;

endmodule
